l1_dcache: RTL and testbench

Parametrised, write-back, write-allocate L1 data cache placed between the memory stage of the pipelined core and the data memory. It answers hits in the same cycle and raises a stall to freeze the pipeline on a miss. While stalled it runs a writeback/refill handshake with the backing memory. It generalises the single-configuration cache slot in the core to configurable sets, 1- or 2-way associativity, byte/half/word access sizes and hit/miss counters.

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_align.sv | 61 ++++++
 rtl/l1_dcache.sv | 213 +++++++++++++++++++++
 tb/tb_l1_dcache.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and address-split constants for the L1 data cache.
//   size_t  : cpu_size access codes (word, byte, byte-unsigned, half, half-unsigned).
//   state_t : miss-handling FSM states.
//   OFFSET_W/INDEX_W/TAG_W : address split for the default 32-set, 32-bit
//   configuration. The cache top derives its own widths from its parameters.
package dcache_pkg;

    typedef enum logic [2:0] {
        SZ_WORD  = 3'b000,
        SZ_BYTE  = 3'b001,
        SZ_BYTEU = 3'b010,
        SZ_HALF  = 3'b011,
        SZ_HALFU = 3'b100
    } size_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    localparam int DEFAULT_SETS   = 32;
    localparam int DEFAULT_ADDR_W = 32;
    localparam int OFFSET_W       = 2;
    localparam int INDEX_W        = $clog2(DEFAULT_SETS);
    localparam int TAG_W          = DEFAULT_ADDR_W - INDEX_W - OFFSET_W;

endpackage

// File: rtl/dcache_align.sv
// dcache_align: combinational lane logic for the L1 data cache.
//   size      : cpu_size code (size_t encoding); unknown codes act as word.
//   offset    : byte offset within the line (addr[1:0]); halves ignore offset[0].
//   lineData  : the hit line's current data.
//   storeData : right-aligned store data.
//   loadData  : selected lane, sign- or zero-extended.
//   byteEn    : store byte enables.
//   mergeData : lineData with the enabled bytes replaced by store data.
module dcache_align
    import dcache_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] lineData,
    input  logic [31:0] storeData,
    output logic [31:0] loadData,
    output logic [3:0]  byteEn,
    output logic [31:0] mergeData
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    logic [31:0] laneData;

    always_comb begin
        byteLane  = lineData[{offset, 3'b000} +: 8];
        halfLane  = offset[1] ? lineData[31:16] : lineData[15:0];
        loadData  = lineData;
        byteEn    = 4'b1111;
        laneData  = storeData;
        mergeData = lineData;
        case (size)
            SZ_BYTE: begin
                loadData = {{24{byteLane[7]}}, byteLane};
                byteEn   = 4'b0001 << offset;
                laneData = {4{storeData[7:0]}};
            end
            SZ_BYTEU: begin
                loadData = {24'h000000, byteLane};
                byteEn   = 4'b0001 << offset;
                laneData = {4{storeData[7:0]}};
            end
            SZ_HALF: begin
                loadData = {{16{halfLane[15]}}, halfLane};
                byteEn   = offset[1] ? 4'b1100 : 4'b0011;
                laneData = {2{storeData[15:0]}};
            end
            SZ_HALFU: begin
                loadData = {16'h0000, halfLane};
                byteEn   = offset[1] ? 4'b1100 : 4'b0011;
                laneData = {2{storeData[15:0]}};
            end
            default: ;
        endcase
        // Store data is replicated into every lane so the enables alone pick the bytes.
        for (int i = 0; i < 4; i++) begin
            if (byteEn[i]) mergeData[8*i +: 8] = laneData[8*i +: 8];
        end
    end

endmodule

// File: rtl/l1_dcache.sv
// l1_dcache: write-back, write-allocate L1 data cache, one-word lines,
// SETS sets x WAYS ways (1 or 2). Hits answer combinationally; a miss raises
// stall and runs WRITEBACK (dirty victim only) then REFILL against memory.
//   clk, rst            : clock, synchronous active-high reset.
//   cpu_load/cpu_store  : request strobes (store wins when both are high).
//   cpu_size/addr/wdata : access size code, byte address, right-aligned store data.
//   cpu_rdata           : extended load data, 0 unless a load hits.
//   stall               : freezes the pipeline while a miss is serviced.
//   mem_*               : backing-memory request/response.
//   hit_count/miss_count: saturating performance counters.
//   dbgState            : current FSM state, for observation.
//
// Memory handshake: the cache raises mem_req and holds mem_we, mem_addr and
// mem_wdata constant until a rising edge where mem_req && mem_ready; that edge
// completes the transfer (mem_rdata is sampled on it for a refill). mem_ready
// has no effect while mem_req is low.
module l1_dcache
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 32,
    parameter int WAYS       = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_load,
    input  logic                  cpu_store,
    input  logic [2:0]            cpu_size,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count,
    output state_t                dbgState
);

    localparam int INDEX_BITS = $clog2(SETS);
    localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - OFFSET_W;

    logic                  validQ [WAYS][SETS];
    logic                  dirtyQ [WAYS][SETS];
    logic [TAG_BITS-1:0]   tagQ   [WAYS][SETS];
    logic [DATA_WIDTH-1:0] dataQ  [WAYS][SETS];

    state_t                stateQ, stateD;
    logic                  victimQ;
    logic [INDEX_BITS-1:0] missIdxQ;
    logic [TAG_BITS-1:0]   missTagQ;
    logic                  afterRefillQ;
    logic [CNT_WIDTH-1:0]  hitCntQ, missCntQ;

    logic [INDEX_BITS-1:0] reqIdx;
    logic [TAG_BITS-1:0]   reqTag;
    logic [WAYS-1:0]       hitVec;
    logic                  hit, hitWay, victimWay, lruWay;
    logic                  hitAccess, missDetect, refillDone;
    logic [DATA_WIDTH-1:0] loadData, mergeData;
    logic [3:0]            byteEn;

    assign reqIdx     = cpu_addr[OFFSET_W +: INDEX_BITS];
    assign reqTag     = cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign hit        = |hitVec;
    assign hit_count  = hitCntQ;
    assign miss_count = missCntQ;
    assign dbgState   = stateQ;

    always_comb begin
        hitVec = '0;
        hitWay = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            hitVec[w] = validQ[w][reqIdx] && (tagQ[w][reqIdx] == reqTag);
            if (hitVec[w]) hitWay = 1'(w);
        end
    end

    // First invalid way wins (way 0 first); a full set falls back to LRU.
    always_comb begin
        if (!validQ[0][reqIdx])           victimWay = 1'b0;
        else if (!validQ[WAYS-1][reqIdx]) victimWay = 1'(WAYS-1);
        else                              victimWay = lruWay;
    end

    dcache_align uAlign (
        .size      (cpu_size),
        .offset    (cpu_addr[1:0]),
        .lineData  (dataQ[hitWay][reqIdx]),
        .storeData (cpu_wdata),
        .loadData  (loadData),
        .byteEn    (byteEn),
        .mergeData (mergeData)
    );

    always_comb begin
        stateD     = stateQ;
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_rdata  = '0;
        hitAccess  = 1'b0;
        missDetect = 1'b0;
        refillDone = 1'b0;
        case (stateQ)
            IDLE: begin
                if (cpu_load || cpu_store) begin
                    if (hit) begin
                        hitAccess = 1'b1;
                        if (!cpu_store) cpu_rdata = loadData;
                    end else begin
                        stall      = 1'b1;
                        missDetect = 1'b1;
                        stateD     = (validQ[victimWay][reqIdx] && dirtyQ[victimWay][reqIdx])
                                     ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tagQ[victimQ][missIdxQ], missIdxQ, 2'b00};
                mem_wdata = dataQ[victimQ][missIdxQ];
                if (mem_ready) stateD = REFILL;
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {missTagQ, missIdxQ, 2'b00};
                if (mem_ready) begin
                    refillDone = 1'b1;
                    stateD     = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ       <= IDLE;
            victimQ      <= 1'b0;
            missIdxQ     <= '0;
            missTagQ     <= '0;
            afterRefillQ <= 1'b0;
            hitCntQ      <= '0;
            missCntQ     <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    validQ[w][s] <= 1'b0;
                    dirtyQ[w][s] <= 1'b0;
                end
            end
        end else begin
            stateQ <= stateD;
            if (missDetect) begin
                victimQ  <= victimWay;
                missIdxQ <= reqIdx;
                missTagQ <= reqTag;
                if (missCntQ != {CNT_WIDTH{1'b1}}) missCntQ <= missCntQ + CNT_WIDTH'(1);
            end
            // The replayed request after a refill is part of the miss, not a new hit.
            if (hitAccess && !afterRefillQ && hitCntQ != {CNT_WIDTH{1'b1}})
                hitCntQ <= hitCntQ + CNT_WIDTH'(1);
            if (hitAccess && cpu_store) dirtyQ[hitWay][reqIdx] <= 1'b1;
            if (stateQ == IDLE) afterRefillQ <= 1'b0;
            if (refillDone) begin
                validQ[victimQ][missIdxQ] <= 1'b1;
                dirtyQ[victimQ][missIdxQ] <= 1'b0;
                afterRefillQ              <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (hitAccess && cpu_store) dataQ[hitWay][reqIdx] <= mergeData;
            if (refillDone) begin
                dataQ[victimQ][missIdxQ] <= mem_rdata;
                tagQ[victimQ][missIdxQ]  <= missTagQ;
            end
        end
    end

    // lruWay names the way to evict next in the requested set.
    generate
        if (WAYS == 2) begin : genLru
            logic lruQ [SETS];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < SETS; s++) lruQ[s] <= 1'b0;
                end else if (refillDone) begin
                    lruQ[missIdxQ] <= ~victimQ;
                end else if (hitAccess) begin
                    lruQ[reqIdx] <= ~hitWay;
                end
            end
            assign lruWay = lruQ[reqIdx];
        end else begin : genNoLru
            assign lruWay = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_l1_dcache.sv
// tb_l1_dcache: directed bench for l1_dcache (SETS=32, WAYS=2). Inputs change
// on the falling edge; outputs are sampled 1 ns later, well before the next
// rising edge. A small memory model answers refills and absorbs writebacks.
module tb_l1_dcache;
    import dcache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_load, cpu_store;
    logic [2:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        stall, mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] hit_count, miss_count;
    state_t      dbgState;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] memArr [logic [31:0]];

    l1_dcache #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .SETS(32), .WAYS(2), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_load(cpu_load), .cpu_store(cpu_store), .cpu_size(cpu_size),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count), .dbgState(dbgState)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (memArr.exists(a)) return memArr[a];
        return ~a;
    endfunction

    always @(negedge clk) mem_rdata <= memRead(mem_addr);

    always @(posedge clk) begin
        if (!rst && mem_req && mem_we && mem_ready) memArr[mem_addr] = mem_wdata;
    end

    // ---------------- driver ----------------
    task automatic drive(input logic ld, input logic st, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        cpu_load  = ld;
        cpu_store = st;
        cpu_size  = sz;
        cpu_addr  = a;
        cpu_wdata = wd;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        drive(1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        assertCount++; if (stall !== 1'b0) begin failCount++; $display("FAIL reset_stall: got %b expected 0", stall); end
        assertCount++; if (mem_req !== 1'b0) begin failCount++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        assertCount++; if (mem_we !== 1'b0) begin failCount++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        assertCount++; if (dbgState !== IDLE) begin failCount++; $display("FAIL reset_state: got %0d expected %0d", dbgState, IDLE); end
        assertCount++; if (hit_count !== 32'd0) begin failCount++; $display("FAIL reset_hit_count: got %0d expected 0", hit_count); end
        assertCount++; if (miss_count !== 32'd0) begin failCount++; $display("FAIL reset_miss_count: got %0d expected 0", miss_count); end
        rst = 1'b0;
    endtask

    task automatic test_load_miss();
        @(negedge clk); drive(1'b1, 1'b0, SZ_WORD, 32'h100, 32'h0); #1;
        assertCount++; if (stall !== 1'b1) begin failCount++; $display("FAIL miss_detect_stall: got %b expected 1", stall); end
        assertCount++; if (mem_req !== 1'b0) begin failCount++; $display("FAIL miss_detect_req: got %b expected 0", mem_req); end
        @(negedge clk); #1;
        assertCount++; if (dbgState !== REFILL) begin failCount++; $display("FAIL miss_refill_state: got %0d expected %0d", dbgState, REFILL); end
        assertCount++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin failCount++; $display("FAIL miss_refill_req: got req=%b we=%b expected req=1 we=0", mem_req, mem_we); end
        assertCount++; if (mem_addr !== 32'h100) begin failCount++; $display("FAIL miss_refill_addr: got %h expected 00000100", mem_addr); end
        assertCount++; if (stall !== 1'b1) begin failCount++; $display("FAIL miss_refill_stall: got %b expected 1", stall); end
        @(negedge clk); #1;
        assertCount++; if (stall !== 1'b0) begin failCount++; $display("FAIL miss_replay_stall: got %b expected 0", stall); end
        assertCount++; if (cpu_rdata !== 32'hDEADBEEF) begin failCount++; $display("FAIL miss_replay_data: got %h expected deadbeef", cpu_rdata); end
        @(negedge clk); #1;
        assertCount++; if (cpu_rdata !== 32'hDEADBEEF) begin failCount++; $display("FAIL repeat_load_data: got %h expected deadbeef", cpu_rdata); end
        @(negedge clk); drive(1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0); #1;
        assertCount++; if (miss_count !== 32'd1) begin failCount++; $display("FAIL miss_count_1: got %0d expected 1", miss_count); end
        assertCount++; if (hit_count !== 32'd1) begin failCount++; $display("FAIL hit_count_1: got %0d expected 1", hit_count); end
    endtask

    task automatic test_store_merge();
        @(negedge clk); drive(1'b0, 1'b1, SZ_BYTE, 32'h101, 32'h80); #1;
        assertCount++; if (stall !== 1'b0) begin failCount++; $display("FAIL store_hit_stall: got %b expected 0", stall); end
        assertCount++; if (cpu_rdata !== 32'h0) begin failCount++; $display("FAIL store_rdata_zero: got %h expected 00000000", cpu_rdata); end
        @(negedge clk); drive(1'b1, 1'b0, SZ_BYTE, 32'h101, 32'h0); #1;
        assertCount++; if (cpu_rdata !== 32'hFFFFFF80) begin failCount++; $display("FAIL load_byte: got %h expected ffffff80", cpu_rdata); end
        @(negedge clk); drive(1'b1, 1'b0, SZ_BYTEU, 32'h101, 32'h0); #1;
        assertCount++; if (cpu_rdata !== 32'h00000080) begin failCount++; $display("FAIL load_byteu: got %h expected 00000080", cpu_rdata); end
        @(negedge clk); drive(1'b1, 1'b0, SZ_WORD, 32'h100, 32'h0); #1;
        assertCount++; if (cpu_rdata !== 32'hDEAD80EF) begin failCount++; $display("FAIL load_word_merged: got %h expected dead80ef", cpu_rdata); end
        @(negedge clk); drive(1'b1, 1'b0, SZ_HALF, 32'h102, 32'h0); #1;
        assertCount++; if (cpu_rdata !== 32'hFFFFDEAD) begin failCount++; $display("FAIL load_half: got %h expected ffffdead", cpu_rdata); end
        @(negedge clk); drive(1'b1, 1'b0, SZ_HALFU, 32'h103, 32'h0); #1;
        assertCount++; if (cpu_rdata !== 32'h0000DEAD) begin failCount++; $display("FAIL load_halfu_odd: got %h expected 0000dead", cpu_rdata); end
        @(negedge clk); drive(1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0); #1;
        assertCount++; if (hit_count !== 32'd7) begin failCount++; $display("FAIL hit_count_7: got %0d expected 7", hit_count); end
    endtask

    task automatic test_eviction();
        @(negedge clk); drive(1'b1, 1'b0, SZ_WORD, 32'h1100, 32'h0); #1;
        assertCount++; if (stall !== 1'b1) begin failCount++; $display("FAIL ev1_detect_stall: got %b expected 1", stall); end
        @(negedge clk); #1;
        assertCount++; if (mem_addr !== 32'h1100 || mem_we !== 1'b0) begin failCount++; $display("FAIL ev1_refill: got addr=%h we=%b expected addr=00001100 we=0", mem_addr, mem_we); end
        @(negedge clk); #1;
        assertCount++; if (stall !== 1'b0 || cpu_rdata !== 32'h11001100) begin failCount++; $display("FAIL ev1_hit: got stall=%b data=%h expected stall=0 data=11001100", stall, cpu_rdata); end
        @(negedge clk); drive(1'b1, 1'b0, SZ_WORD, 32'h2100, 32'h0); #1;
        assertCount++; if (stall !== 1'b1) begin failCount++; $display("FAIL ev2_detect_stall: got %b expected 1", stall); end
        @(negedge clk); #1;
        assertCount++; if (dbgState !== WRITEBACK || mem_we !== 1'b1) begin failCount++; $display("FAIL ev2_wb_state: got state=%0d we=%b expected state=%0d we=1", dbgState, mem_we, WRITEBACK); end
        assertCount++; if (mem_addr !== 32'h100) begin failCount++; $display("FAIL ev2_wb_addr: got %h expected 00000100", mem_addr); end
        assertCount++; if (mem_wdata !== 32'hDEAD80EF) begin failCount++; $display("FAIL ev2_wb_data: got %h expected dead80ef", mem_wdata); end
        @(negedge clk); #1;
        assertCount++; if (dbgState !== REFILL || mem_we !== 1'b0 || mem_addr !== 32'h2100) begin failCount++; $display("FAIL ev2_refill: got state=%0d we=%b addr=%h expected state=%0d we=0 addr=00002100", dbgState, mem_we, mem_addr, REFILL); end
        @(negedge clk); #1;
        assertCount++; if (stall !== 1'b0 || cpu_rdata !== 32'h21002100) begin failCount++; $display("FAIL ev2_hit: got stall=%b data=%h expected stall=0 data=21002100", stall, cpu_rdata); end
        @(negedge clk); drive(1'b1, 1'b0, SZ_WORD, 32'h100, 32'h0); #1;
        assertCount++; if (stall !== 1'b1) begin failCount++; $display("FAIL ev3_detect_stall: got %b expected 1", stall); end
        @(negedge clk); #1;
        assertCount++; if (dbgState !== REFILL || mem_addr !== 32'h100) begin failCount++; $display("FAIL ev3_refill: got state=%0d addr=%h expected state=%0d addr=00000100", dbgState, mem_addr, REFILL); end
        @(negedge clk); #1;
        assertCount++; if (stall !== 1'b0 || cpu_rdata !== 32'hDEAD80EF) begin failCount++; $display("FAIL ev3_written_back_data: got stall=%b data=%h expected stall=0 data=dead80ef", stall, cpu_rdata); end
    endtask

    task automatic test_ready_hold();
        @(negedge clk); mem_ready = 1'b0; drive(1'b1, 1'b0, SZ_WORD, 32'h304, 32'h0); #1;
        assertCount++; if (stall !== 1'b1) begin failCount++; $display("FAIL hold_detect_stall: got %b expected 1", stall); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            assertCount++; if (stall !== 1'b1 || mem_req !== 1'b1) begin failCount++; $display("FAIL hold_stall_req[%0d]: got stall=%b req=%b expected 1 1", i, stall, mem_req); end
            assertCount++; if (mem_addr !== 32'h304 || mem_we !== 1'b0) begin failCount++; $display("FAIL hold_addr[%0d]: got addr=%h we=%b expected addr=00000304 we=0", i, mem_addr, mem_we); end
            assertCount++; if (dbgState !== REFILL) begin failCount++; $display("FAIL hold_state[%0d]: got %0d expected %0d", i, dbgState, REFILL); end
        end
        @(negedge clk); mem_ready = 1'b1; #1;
        assertCount++; if (dbgState !== REFILL) begin failCount++; $display("FAIL hold_release_state: got %0d expected %0d", dbgState, REFILL); end
        @(negedge clk); #1;
        assertCount++; if (stall !== 1'b0 || cpu_rdata !== 32'hFFFFFCFB) begin failCount++; $display("FAIL hold_hit: got stall=%b data=%h expected stall=0 data=fffffcfb", stall, cpu_rdata); end
    endtask

    task automatic test_reset_mid_miss();
        @(negedge clk); drive(1'b0, 1'b1, SZ_WORD, 32'h008, 32'hAAAA5555); #1;
        assertCount++; if (stall !== 1'b1) begin failCount++; $display("FAIL rm_store_miss: got %b expected 1", stall); end
        @(negedge clk);
        @(negedge clk); #1;
        assertCount++; if (stall !== 1'b0) begin failCount++; $display("FAIL rm_store_merge_stall: got %b expected 0", stall); end
        @(negedge clk); drive(1'b1, 1'b0, SZ_WORD, 32'h088, 32'h0);
        @(negedge clk);
        @(negedge clk); #1;
        assertCount++; if (stall !== 1'b0) begin failCount++; $display("FAIL rm_second_line: got %b expected 0", stall); end
        @(negedge clk); mem_ready = 1'b0; drive(1'b1, 1'b0, SZ_WORD, 32'h108, 32'h0);
        @(negedge clk); #1;
        assertCount++; if (dbgState !== WRITEBACK || mem_addr !== 32'h008 || mem_wdata !== 32'hAAAA5555) begin failCount++; $display("FAIL rm_wb: got state=%0d addr=%h data=%h expected state=%0d addr=00000008 data=aaaa5555", dbgState, mem_addr, mem_wdata, WRITEBACK); end
        rst = 1'b1;
        drive(1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        @(negedge clk); #1;
        assertCount++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failCount++; $display("FAIL rm_after_reset: got req=%b stall=%b expected 0 0", mem_req, stall); end
        assertCount++; if (dbgState !== IDLE || miss_count !== 32'd0) begin failCount++; $display("FAIL rm_after_reset_state: got state=%0d misses=%0d expected state=%0d misses=0", dbgState, miss_count, IDLE); end
        rst = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk); drive(1'b1, 1'b0, SZ_WORD, 32'h008, 32'h0); #1;
        assertCount++; if (stall !== 1'b1) begin failCount++; $display("FAIL rm_reload_misses: got %b expected 1", stall); end
        @(negedge clk);
        @(negedge clk); #1;
        assertCount++; if (stall !== 1'b0 || cpu_rdata !== 32'hFFFFFFF7) begin failCount++; $display("FAIL rm_discarded_victim: got stall=%b data=%h expected stall=0 data=fffffff7", stall, cpu_rdata); end
    endtask

    task automatic test_load_store_together();
        @(negedge clk); drive(1'b1, 1'b1, SZ_WORD, 32'h200, 32'h12345678); #1;
        assertCount++; if (stall !== 1'b1) begin failCount++; $display("FAIL ls_detect_stall: got %b expected 1", stall); end
        @(negedge clk); #1;
        assertCount++; if (mem_addr !== 32'h200) begin failCount++; $display("FAIL ls_refill_addr: got %h expected 00000200", mem_addr); end
        @(negedge clk); #1;
        assertCount++; if (stall !== 1'b0 || cpu_rdata !== 32'h0) begin failCount++; $display("FAIL ls_store_wins: got stall=%b data=%h expected stall=0 data=00000000", stall, cpu_rdata); end
        @(negedge clk); drive(1'b1, 1'b0, SZ_WORD, 32'h200, 32'h0); #1;
        assertCount++; if (cpu_rdata !== 32'h12345678) begin failCount++; $display("FAIL ls_readback: got %h expected 12345678", cpu_rdata); end
        @(negedge clk); drive(1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0); #1;
        assertCount++; if (miss_count !== 32'd2 || hit_count !== 32'd1) begin failCount++; $display("FAIL ls_counters: got miss=%0d hit=%0d expected miss=2 hit=1", miss_count, hit_count); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        memArr[32'h100]  = 32'hDEADBEEF;
        memArr[32'h1100] = 32'h11001100;
        memArr[32'h2100] = 32'h21002100;
        test_reset();
        test_load_miss();
        test_store_merge();
        test_eviction();
        test_ready_hold();
        test_reset_mid_miss();
        test_load_store_together();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
